// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants and the sync bundle type
`timescale 1ns/1ps
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_TOTAL  = 525;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_b;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_b: 1'b0};

    // Sync bundle for a raster position; syncs are active-low pulses after the front porch.
    function automatic sync_t sync_at(input int h, input int v,
                                      input int h_act, input int h_fp, input int h_sync,
                                      input int v_act, input int v_fp, input int v_sync);
        sync_t s;
        s.hsync   = !(h >= h_act + h_fp && h < h_act + h_fp + h_sync);
        s.vsync   = !(v >= v_act + v_fp && v < v_act + v_fp + v_sync);
        s.blank_b = (h < h_act) && (v < v_act);
        return s;
    endfunction

endpackage

// File: rtl/vga_delay.sv
// rtl/vga_delay.sv - pixel-enable shift register that lines syncs up with pixel data
`timescale 1ns/1ps
module vga_delay #(
    parameter int  DEPTH = 1,
    parameter type T     = logic,
    parameter T    IDLE  = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  T     d,
    output T     q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            T stages [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= IDLE;
                end else if (en) begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counters, pixel clock and delayed sync generation
`timescale 1ns/1ps
module vga_timing
    import vga_pkg::*;
#(
    parameter int PIPE_DELAY = 1,
    parameter int PIX_DIV    = 2,
    parameter int H_ACT      = H_ACTIVE,
    parameter int H_FRONT    = H_FP,
    parameter int H_SW       = H_SYNC,
    parameter int H_TOT      = H_TOTAL,
    parameter int V_ACT      = V_ACTIVE,
    parameter int V_FRONT    = V_FP,
    parameter int V_SW       = V_SYNC,
    parameter int V_TOT      = V_TOTAL
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       vga_clk,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_b,
    output logic       sync_b,
    output logic       frame_start
);

    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DW-1:0] div, div_nxt;
    logic          pix_en;
    logic          running;
    logic [9:0]    hcnt, vcnt, hcnt_nxt, vcnt_nxt;
    sync_t         sync_now, sync_nxt, sync_dly;

    // The first pixel tick after reset presents (0,0) instead of advancing past it.
    always_comb begin
        pix_en   = (div == DW'(PIX_DIV - 1));
        div_nxt  = pix_en ? '0 : div + 1'b1;
        hcnt_nxt = hcnt;
        vcnt_nxt = vcnt;
        if (running) begin
            if (hcnt == 10'(H_TOT - 1)) begin
                hcnt_nxt = '0;
                vcnt_nxt = (vcnt == 10'(V_TOT - 1)) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt_nxt = hcnt + 1'b1;
            end
        end
        sync_nxt = sync_at(int'(hcnt_nxt), int'(vcnt_nxt),
                           H_ACT, H_FRONT, H_SW, V_ACT, V_FRONT, V_SW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            running     <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            vga_clk     <= 1'b0;
            sync_now    <= SYNC_IDLE;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            vga_clk     <= (int'(div_nxt) >= PIX_DIV / 2);
            frame_start <= pix_en && (hcnt_nxt == '0) && (vcnt_nxt == '0);
            if (pix_en) begin
                running  <= 1'b1;
                hcnt     <= hcnt_nxt;
                vcnt     <= vcnt_nxt;
                sync_now <= sync_nxt;
            end
        end
    end

    vga_delay #(
        .DEPTH (PIPE_DELAY),
        .T     (sync_t),
        .IDLE  (SYNC_IDLE)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .d     (sync_now),
        .q     (sync_dly)
    );

    assign x       = hcnt;
    assign y       = vcnt;
    assign hsync   = sync_dly.hsync;
    assign vsync   = sync_dly.vsync;
    assign blank_b = sync_dly.blank_b;
    assign sync_b  = 1'b0;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter PIPE_DELAY, default 1: pixel-tick delay applied to hsync/vsync/blank_b to match the pixel-data path latency.
REQ-002 Parameter PIX_DIV, default 2: clk cycles per pixel tick.
REQ-003 clk  input  1  system clock, 50 MHz; the only clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 vga_clk  output  1  pixel clock to the DAC, 25 MHz for PIX_DIV=2.
REQ-006 x  output  10  current horizontal pixel counter, not delayed.
REQ-007 y  output  10  current vertical line counter, not delayed.
REQ-008 hsync  output  1  horizontal sync, active-low, delayed PIPE_DELAY ticks.
REQ-009 vsync  output  1  vertical sync, active-low, delayed PIPE_DELAY ticks.
REQ-010 blank_b  output  1  high in the visible region, delayed PIPE_DELAY ticks.
REQ-011 sync_b  output  1  constant 0; composite sync is not used.
REQ-012 frame_start  output  1  single-clk pulse at the tick where x=0, y=0.

Function
REQ-013 The pixel enable SHALL assert for one clk every PIX_DIV clks, from a divider counting 0..PIX_DIV-1.
REQ-014 vga_clk SHALL be low for the first half of each divider period and high for the second half.
- The rising edge of vga_clk falls mid-pixel.
REQ-015 Counters hcnt and vcnt SHALL change only on pixel-enable clks.
REQ-016 hcnt SHALL count 0..799 and then wrap to 0; H_TOTAL=800.
REQ-017 vcnt SHALL increment only on the hcnt 799->0 wrap, count 0..524, and wrap to 0; V_TOTAL=525.
- Simultaneous wrap of both counters: next tick x=0, y=0.
REQ-018 x SHALL equal hcnt and y SHALL equal vcnt, driven from registers with no delay.
- Downstream memory address generation uses x and y directly.
REQ-019 Undelayed hsync SHALL be 0 exactly for hcnt 656..751, i.e. H_ACTIVE 640 + front porch 16, width 96.
REQ-020 Undelayed vsync SHALL be 0 exactly for vcnt 490..491, i.e. V_ACTIVE 480 + front porch 10, width 2.
REQ-021 Undelayed blank_b SHALL be 1 if and only if hcnt<640 and vcnt<480.
REQ-022 The hsync/vsync/blank_b outputs SHALL equal their undelayed values from PIPE_DELAY pixel ticks earlier.
- PIPE_DELAY=0 means direct registered values with no added delay.
REQ-023 frame_start SHALL be 1 only on the pixel-enable clk at which hcnt=0 and vcnt=0; it is 0 on every other clk.
REQ-024 All outputs SHALL be registered; there is no combinational path from inputs to outputs.
REQ-025 The frame period SHALL be 420000 pixel ticks, i.e. 840000 clk for PIX_DIV=2.

Reset
REQ-026 While rst_n=0, registers SHALL take these values: divider=0, hcnt=0, vcnt=0, vga_clk=0, hsync=1, vsync=1, blank_b=0, frame_start=0.
REQ-027 Reset SHALL fill every delay-line stage with the idle values (1,1,0) for (hsync, vsync, blank_b).
REQ-028 Reset asserted mid-frame SHALL clear the outputs immediately, without waiting for clk.
REQ-029 After release, the first pixel enable SHALL occur PIX_DIV clks after the first clk edge with rst_n=1.
- frame_start pulses on that first pixel enable.

Structure
REQ-030 Package vga_pkg SHALL hold the timing constants: H_ACTIVE, H_FP, H_SYNC, H_TOTAL, V_ACTIVE, V_FP, V_SYNC, V_TOTAL.
- The same package SHALL hold a packed struct of the sync bundle (hsync, vsync, blank_b).
REQ-031 Sub-module vga_delay SHALL implement the shift register advanced on pixel enable.
- Parameterised by depth and bundle type; reset to the idle bundle; depth 0 is a pass-through.

Verification
REQ-032 Reset scenario: hold rst_n=0 for 5 clk, release -> outputs at reset values during reset; frame_start=1 at clk 2 after release, with x=0, y=0.
REQ-033 Line timing: run 1 line -> undelayed hsync low for 96 ticks (192 clk) starting at x=656; blank_b high for x 0..639 (delayed by PIPE_DELAY).
REQ-034 Frame wrap: run to x=799, y=524 -> next tick x=0, y=0 and frame_start=1; interval between frame_start pulses is 840000 clk.
REQ-035 Vsync: vsync low exactly 2 lines (1600 ticks) starting at y=490, x=0 (plus PIPE_DELAY ticks); never low elsewhere.
REQ-036 Delay alignment: PIPE_DELAY=2 -> blank_b rises 2 ticks after x=0, y=0.
- Also run PIPE_DELAY=0 -> blank_b rises on the same tick as x=0, y=0.
REQ-037 Mid-frame reset: assert rst_n=0 at x=300, y=200 -> within the same clk x=0, y=0, hsync=1, blank_b=0; restart as in REQ-032.
